// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, MUL decode codes, MUL sequencer state encoding.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
//
// Imported by the ALU control decoder and by alu_mul_sequencer so both agree
// on the MUL encoding and on the operand width.
package alu_pkg;

    // Operand / result-word width of the integer datapath.
    localparam int DATA_WIDTH = 24;

    // ALUOp value that decode emits for the multiply class.
    localparam logic [1:0] ALUOP_MUL = 2'b11;

    // Operation code selecting MUL within that class.
    localparam logic [3:0] OP_MUL = 4'b0101;

    // Multiply sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // True when the decoded (operation, ALUOp) pair is a MUL. Decode uses this
    // to raise start on the sequencer.
    function automatic logic is_mul_op(input logic [3:0] op, input logic [1:0] aluop);
        return (op == OP_MUL) && (aluop == ALUOP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Decode/writeback-facing bundle of the MUL sequencer.
// Latency: n/a (wiring only).
// Backpressure: busy is the stall back to decode; there is no ready on the result.
//
// Signals:
//   start, kill      decode -> sequencer  issue / flush
//   op_a, op_b       decode -> sequencer  multiplicand / multiplier
//   busy             sequencer -> hazard  stall request
//   done             sequencer -> wb      one-cycle result strobe
//   result_lo/hi     sequencer -> wb      low / high product words
// master = decode/writeback side, slave = the sequencer.
interface alu_mul_sequencer_if #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
);
    logic                  start;
    logic                  kill;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result_lo;
    logic [DATA_WIDTH-1:0] result_hi;

    modport master (
        output start,
        output kill,
        output op_a,
        output op_b,
        input  busy,
        input  done,
        input  result_lo,
        input  result_hi
    );

    modport slave (
        input  start,
        input  kill,
        input  op_a,
        input  op_b,
        output busy,
        output done,
        output result_lo,
        output result_hi
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned radix-2 shift-add multiplier for the ALU MUL op, one multiplier bit per cycle.
// Latency: accept at edge E0, DATA_WIDTH RUN cycles, done in cycle DATA_WIDTH+1 (fewer RUN cycles with MUL_EARLY_TERM_EN).
// Backpressure: busy stalls the pipeline in RUN/DONE; start outside IDLE is dropped, never queued.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   mul_if  slave side of alu_mul_sequencer_if (start/kill/op_a/op_b in,
//           busy/done/result_lo/result_hi out)
//
// Build option: define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining
// multiplier bits are all zero. The product is unchanged because the
// multiplicand is shifted left in place, so nothing needs realigning.
//
// COUNT_WIDTH must satisfy 2**COUNT_WIDTH >= DATA_WIDTH.
module alu_mul_sequencer #(
    parameter int DATA_WIDTH  = alu_pkg::DATA_WIDTH,
    parameter int COUNT_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_mul_sequencer_if.slave mul_if
);
    import alu_pkg::*;

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    // Count value during the final full-width RUN step.
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mul_state_e              state_q,  state_d;
    logic [PROD_WIDTH-1:0]   acc_q,    acc_d;
    logic [PROD_WIDTH-1:0]   mcand_q,  mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [COUNT_WIDTH-1:0]  count_q,  count_d;
    logic [PROD_WIDTH-1:0]   result_q, result_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;

    // Datapath helpers for one RUN step.
    logic [PROD_WIDTH-1:0]   acc_step;
    logic [DATA_WIDTH-1:0]   mplier_shift;
    logic                    last_step;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;

        // One shift-add step. The accumulator is twice the operand width,
        // so the sum can never overflow.
        acc_step     = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shift = mplier_q >> 1;

`ifdef MUL_EARLY_TERM_EN
        // Stop once no set multiplier bits remain; further steps would only
        // add zero.
        last_step = (count_q == LAST_COUNT) || (mplier_shift == '0);
`else
        last_step = (count_q == LAST_COUNT);
`endif

        unique case (state_q)
            IDLE: begin
                // kill has priority over start: a flushed issue is dropped.
                if (mul_if.start && !mul_if.kill) begin
                    state_d  = RUN;
                    mcand_d  = {{DATA_WIDTH{1'b0}}, mul_if.op_a};
                    mplier_d = mul_if.op_b;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end

            RUN: begin
                if (mul_if.kill) begin
                    // Abort: results keep the previous product, no done.
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shift;
                    count_d  = count_q + COUNT_WIDTH'(1);
                    if (last_step) begin
                        // Result and done are loaded together so that both
                        // are visible from the first DONE cycle.
                        state_d  = DONE;
                        result_d = acc_step;
                        done_d   = 1'b1;
                    end
                end
            end

            DONE: begin
                // kill here also lands in IDLE; done has already been
                // presented for this cycle and cannot be withdrawn.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered stall: decode covers the accept cycle itself
        // combinationally, this flop covers RUN and DONE.
        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from flops, no input-to-output paths.
    // ------------------------------------------------------------------
    assign mul_if.busy      = busy_q;
    assign mul_if.done      = done_q;
    assign mul_if.result_lo = result_q[DATA_WIDTH-1:0];
    assign mul_if.result_hi = result_q[PROD_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer.
// Latency: n/a (testbench).
// Backpressure: n/a (bench honours busy by only issuing from IDLE except in the ignored-start case).
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    localparam int W = alu_pkg::DATA_WIDTH;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    alu_mul_sequencer_if #(.DATA_WIDTH(W)) mul_if ();

    alu_mul_sequencer #(
        .DATA_WIDTH (W),
        .COUNT_WIDTH(5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mul_if(mul_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[7];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Number of RUN cycles the sequencer should spend on multiplier b.
    function automatic int exp_run(input logic [W-1:0] b);
        int n;
        n = W;
        if (EARLY) begin
            n = 1;
            for (int i = 0; i < W; i++)
                if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    // Issue one multiply from IDLE and follow it until done (bounded).
    // Optionally pulses a second start at cycle stray_cyc.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stray_cyc,
                           input logic [W-1:0] sa, input logic [W-1:0] sb,
                           output int done_cyc, output int busy_low,
                           output logic [W-1:0] got_hi, output logic [W-1:0] got_lo);
        int cyc;
        mul_if.op_a  = a;
        mul_if.op_b  = b;
        mul_if.start = is_mul_op(OP_MUL, ALUOP_MUL);
        tick();
        // Scramble the operand bus: only the accept-edge values may matter.
        mul_if.start = 1'b0;
        mul_if.op_a  = W'($urandom);
        mul_if.op_b  = W'($urandom);
        cyc      = 1;
        done_cyc = -1;
        busy_low = 0;
        got_hi   = '0;
        got_lo   = '0;
        while (done_cyc < 0 && cyc <= 60) begin
            if (!mul_if.busy) busy_low++;
            if (mul_if.done) begin
                done_cyc = cyc;
                got_hi   = mul_if.result_hi;
                got_lo   = mul_if.result_lo;
            end
            if (cyc == stray_cyc) begin
                mul_if.start = 1'b1;
                mul_if.op_a  = sa;
                mul_if.op_b  = sb;
            end else begin
                mul_if.start = 1'b0;
            end
            tick();
            cyc++;
        end
        mul_if.start = 1'b0;
    endtask

    task automatic verify_mul(input string tag,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                              input int stray_cyc,
                              input logic [W-1:0] sa, input logic [W-1:0] sb);
        int           done_cyc;
        int           busy_low;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        run_mul(a, b, stray_cyc, sa, sb, done_cyc, busy_low, hi, lo);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_run(b) + 1));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_busy_gap"}, 64'(busy_low), 64'd0);
        // Now in the cycle after DONE: back in IDLE, pulse over.
        check({tag, "_busy_after"}, 64'(mul_if.busy), 64'd0);
        check({tag, "_done_pulse"}, 64'(mul_if.done), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] prod;
        int             n_done;
        int             n_busy;

        vecs[0] = '{a: 24'h000003, b: 24'h000004, exp_hi: 24'h000000, exp_lo: 24'h00000C};
        vecs[1] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, exp_hi: 24'hFFFFFE, exp_lo: 24'h000001};
        vecs[2] = '{a: 24'h123456, b: 24'h000100, exp_hi: 24'h000012, exp_lo: 24'h345600};
        vecs[3] = '{a: 24'hABCDEF, b: 24'h000000, exp_hi: 24'h000000, exp_lo: 24'h000000};
        vecs[4] = '{a: 24'h000001, b: 24'hFFFFFF, exp_hi: 24'h000000, exp_lo: 24'hFFFFFF};
        vecs[5] = '{a: 24'h800000, b: 24'h800000, exp_hi: 24'h400000, exp_lo: 24'h000000};
        vecs[6] = '{a: 24'h000007, b: 24'h000001, exp_hi: 24'h000000, exp_lo: 24'h000007};

        reset        = 1'b1;
        mul_if.start = 1'b0;
        mul_if.kill  = 1'b0;
        mul_if.op_a  = '0;
        mul_if.op_b  = '0;

        // Reset values.
        #1;
        check("reset_busy", 64'(mul_if.busy), 64'd0);
        check("reset_done", 64'(mul_if.done), 64'd0);
        check("reset_lo", 64'(mul_if.result_lo), 64'd0);
        check("reset_hi", 64'(mul_if.result_hi), 64'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Directed vectors.
        for (int i = 0; i < 7; i++)
            verify_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                       vecs[i].exp_hi, vecs[i].exp_lo, -1, '0, '0);

        // Random operands with varied multiplier widths.
        for (int i = 0; i < 20; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom) & W'((32'd1 << $urandom_range(0, W)) - 1);
            prod = (2 * W)'(ra) * (2 * W)'(rb);
            verify_mul($sformatf("rand%0d", i), ra, rb, prod[2*W-1:W], prod[W-1:0],
                       -1, '0, '0);
        end

        // Asynchronous reset in the middle of RUN (cycle 10).
        mul_if.op_a  = 24'd5;
        mul_if.op_b  = EARLY ? 24'h800007 : 24'd7;
        mul_if.start = 1'b1;
        tick();
        mul_if.start = 1'b0;
        repeat (9) tick();
        check("midrun_busy_before", 64'(mul_if.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", 64'(mul_if.busy), 64'd0);
        check("midrun_reset_done", 64'(mul_if.done), 64'd0);
        check("midrun_reset_lo", 64'(mul_if.result_lo), 64'd0);
        check("midrun_reset_hi", 64'(mul_if.result_hi), 64'd0);
        reset  = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (mul_if.done) n_done++;
            if (mul_if.busy) n_busy++;
        end
        check("midrun_no_done", 64'(n_done), 64'd0);
        check("midrun_no_busy", 64'(n_busy), 64'd0);

        // Start during RUN is dropped; no second operation follows.
        verify_mul("ignored_start", 24'd3, 24'd4, 24'd0, 24'd12, EARLY ? 2 : 5, 24'd9, 24'd9);
        n_busy = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mul_if.busy) n_busy++;
        end
        check("ignored_start_no_queue", 64'(n_busy), 64'd0);

        // Kill at cycle 12.
        verify_mul("pre_kill", 24'd7, 24'd6, 24'd0, 24'd42, -1, '0, '0);
        mul_if.op_a  = 24'h000ABC;
        mul_if.op_b  = 24'hFFFFFF;
        mul_if.start = 1'b1;
        tick();
        mul_if.start = 1'b0;
        repeat (11) tick();
        check("kill_busy_before", 64'(mul_if.busy), 64'd1);
        mul_if.kill = 1'b1;
        tick();
        mul_if.kill = 1'b0;
        check("kill_busy_next", 64'(mul_if.busy), 64'd0);
        check("kill_done_next", 64'(mul_if.done), 64'd0);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (mul_if.done) n_done++;
        end
        check("kill_no_done", 64'(n_done), 64'd0);
        check("kill_keep_lo", 64'(mul_if.result_lo), 64'd42);
        check("kill_keep_hi", 64'(mul_if.result_hi), 64'd0);

        // kill together with start in IDLE: nothing accepted.
        mul_if.op_a  = 24'd11;
        mul_if.op_b  = 24'd13;
        mul_if.start = 1'b1;
        mul_if.kill  = 1'b1;
        tick();
        mul_if.start = 1'b0;
        mul_if.kill  = 1'b0;
        check("kill_start_busy0", 64'(mul_if.busy), 64'd0);
        tick();
        check("kill_start_busy1", 64'(mul_if.busy), 64'd0);
        check("kill_start_keep_lo", 64'(mul_if.result_lo), 64'd42);

        // Normal operation resumes afterwards.
        verify_mul("post_kill", 24'd3, 24'd4, 24'd0, 24'd12, -1, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
